master_cmd_loader: RTL and testbench
====================================

Name: master_cmd_loader

Overview:
Operator-command front end that sits directly upstream of one bus master and drives its command-load port: read, write, data_load, address_load, slave_select_load and burst_num_load. It debounces three raw push-buttons and steps through a field-entry state machine, latching the 12-bit switch array into each command field in turn. It then issues a single-cycle read or write strobe when the master is idle, and tracks the master's busy flag until the transaction completes. One instance is required per master (M1, M2).

Parameters:
SLAVE_LEN, 2, slave-select field width
ADDR_LEN, 12, address width; the address output is ADDR_LEN+1 bits
DATA_LEN, 8, write-data width
BURST_LEN, 12, burst width; the burst output is BURST_LEN+1 bits
DEBOUNCE_CYCLES, 4, number of stable clk cycles required before a press is accepted

Ports:
clk  in  1  system (scaled) clock
rst  in  1  asynchronous reset, active-low
btn_next_n  in  1  raw button, active-low: latch the current field and advance
btn_back_n  in  1  raw button, active-low: return to the previous field
btn_go_n  in  1  raw button, active-low: issue the command
switch_array  in  12  field value entry
rw_switch  in  1  1 = write, 0 = read
master_busy  in  1  busy output of the attached master
read  out  1  one-cycle read strobe to the master
write  out  1  one-cycle write strobe to the master
data  out  DATA_LEN  write data
address  out  ADDR_LEN+1  target address
slave  out  SLAVE_LEN  target slave code
burst_num  out  BURST_LEN+1  burst length
config_state  out  4  current FSM state code, for display
field_err  out  1  sticky: the last latch attempt was rejected

Behaviour:
Interface and reset:
- One clock, clk. Reset rst is asynchronous and active-low.
- While rst=0, and immediately on assertion (including mid-transaction), all outputs and all state clear to 0, and the FSM returns to S_SLAVE. The debouncer counters and synchronizers also clear.

Button conditioning:
- Each button passes through a 2-flop synchronizer, is inverted, and feeds a stability counter.
- A press pulse (1 clk) is emitted when the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles.
- No further pulse is emitted until the level has been low for DEBOUNCE_CYCLES cycles.
- Latency from a raw falling edge to the pulse is 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.

FSM states (config_state code in brackets):
- S_SLAVE (0): next_p latches slave = switch_array[SLAVE_LEN-1:0].
  - Code 3 is rejected: field_err=1 and the FSM stays in S_SLAVE.
  - Codes 0–2 are accepted: field_err=0 and the FSM moves to S_ADDR.
- S_ADDR (1): next_p latches address = {1'b0, switch_array[11:0]}, then moves to S_DATA.
- S_DATA (2): next_p latches data = switch_array[DATA_LEN-1:0], then moves to S_BURST.
- S_BURST (3): next_p latches burst_num = {1'b0, switch_array}.
  - Value 0 is rejected: field_err=1 and the FSM stays in S_BURST.
  - Otherwise the FSM moves to S_ARMED.
- S_ARMED (4): go_p with master_busy=0 moves to S_ISSUE. go_p while master_busy=1 is ignored (it is not queued).
- S_ISSUE (5): for exactly one cycle, write=rw_switch and read=~rw_switch. rw_switch is sampled in this cycle. The FSM then moves to S_WAIT.
- S_WAIT (6):
  - Once master_busy has been seen at 1 and then returns to 0, the FSM goes to S_ARMED. Fields are retained so the same command can be repeated.
  - If busy never rises within 8 cycles of the strobe, the FSM returns to S_ARMED and sets field_err=1.

Back button:
- back_p in S_ADDR, S_DATA, S_BURST or S_ARMED moves to the previous state. Latched fields are not cleared.
- back_p in S_SLAVE, S_ISSUE or S_WAIT is ignored.

Simultaneous pulses in one cycle:
- back_p has priority over next_p.
- go_p is honoured only in S_ARMED. next_p is ignored in S_ARMED, S_ISSUE and S_WAIT.

Other rules:
- read and write are never high together and never high for more than one cycle per go.
- Field outputs are stable whenever read or write is high.
- Unused state codes 7–15 recover to S_SLAVE on the next clock.

Decomposition:
- Shared package cmd_pkg holds:
  - the FSM state encodings S_SLAVE..S_WAIT (4-bit);
  - SLAVE_CODE_MAX = 2;
  - WAIT_TIMEOUT = 8.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) contains the synchronizer, stability counter and press pulse. It is instantiated three times.

Test Plan:
1. Reset, then enter slave=1, addr=0x0A5, data=0x3C, burst=4; hold rw_switch=1 and press go with master_busy=0. Expect exactly one write pulse with slave=1, address=0x00A5, data=0x3C, burst_num=4, and config_state 4→5→6.
2. With a loaded command, rw_switch=0, master_busy rising 2 cycles after the strobe and falling 10 cycles later. Expect one read pulse and S_WAIT held until busy falls, then config_state=4.
3. Switch=3 with next in S_SLAVE: expect field_err=1, config_state=0. Then switch=0 in S_BURST: expect field_err=1, config_state=3.
4. 2-cycle glitch on btn_next_n (DEBOUNCE_CYCLES=4): no state change. Same-cycle next and back in S_DATA: expect config_state=1.
5. Go while master_busy=1: no strobe, state stays 4. Strobe with busy never rising: return to 4 after 8 cycles, field_err=1.
6. Assert rst=0 asynchronously in S_WAIT: all outputs 0 immediately. After release: config_state=0, and no spurious pulse while a button is held through reset.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the master command loader: FSM state codes,
// field limits and the transaction timeout.
package cmd_pkg;

  typedef enum logic [3:0] {
    S_SLAVE = 4'd0,
    S_ADDR  = 4'd1,
    S_DATA  = 4'd2,
    S_BURST = 4'd3,
    S_ARMED = 4'd4,
    S_ISSUE = 4'd5,
    S_WAIT  = 4'd6
  } state_e;

  localparam int SLAVE_CODE_MAX = 2;
  localparam int WAIT_TIMEOUT   = 8;

  function automatic logic slave_ok(input logic [31:0] code);
    return (code <= 32'(SLAVE_CODE_MAX));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle press pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_p
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          rel_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

  // rel_r holds the accepted level in raw polarity; its reset value of 0
  // reads as "pressed", so a button held through reset never pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_r   <= 1'b0;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else if (sync2_r != rel_r) begin
      if (cnt_r == CNT_LAST) begin
        rel_r   <= sync2_r;
        cnt_r   <= '0;
        press_r <= ~sync2_r;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
        press_r <= 1'b0;
      end
    end else begin
      cnt_r   <= '0;
      press_r <= 1'b0;
    end
  end

  assign press_p = press_r;

endmodule

// File: rtl/master_cmd_loader.sv
// Operator front end for one bus master: field entry from switches via
// debounced buttons, then a single read/write strobe and busy tracking.
module master_cmd_loader
  import cmd_pkg::*;
#(
  parameter int SLAVE_LEN       = 2,
  parameter int ADDR_LEN        = 12,
  parameter int DATA_LEN        = 8,
  parameter int BURST_LEN       = 12,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next_n,
  input  logic                 btn_back_n,
  input  logic                 btn_go_n,
  input  logic [11:0]          switch_array,
  input  logic                 rw_switch,
  input  logic                 master_busy,
  output logic                 read,
  output logic                 write,
  output logic [DATA_LEN-1:0]  data,
  output logic [ADDR_LEN:0]    address,
  output logic [SLAVE_LEN-1:0] slave,
  output logic [BURST_LEN:0]   burst_num,
  output logic [3:0]           config_state,
  output logic                 field_err
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_TIMEOUT - 1);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic                   next_p_s;
  logic                   back_p_s;
  logic                   go_p_s;
  logic                   ld_slave_s;
  logic                   ld_addr_s;
  logic                   ld_data_s;
  logic                   ld_burst_s;
  logic                   err_set_s;
  logic                   err_clr_s;
  logic                   field_err_r;
  logic                   seen_busy_r;
  logic [3:0]             wait_cnt_r;
  logic [SLAVE_LEN-1:0]   slave_r;
  logic [ADDR_LEN:0]      address_r;
  logic [DATA_LEN-1:0]    data_r;
  logic [BURST_LEN:0]     burst_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .btn_n(btn_next_n), .press_p(next_p_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .rst(rst), .btn_n(btn_back_n), .press_p(back_p_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (
    .clk(clk), .rst(rst), .btn_n(btn_go_n), .press_p(go_p_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_SLAVE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and field-load decode; back wins wherever it is legal.
  always_comb begin
    state_nxt_s = state_r;
    ld_slave_s  = 1'b0;
    ld_addr_s   = 1'b0;
    ld_data_s   = 1'b0;
    ld_burst_s  = 1'b0;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    case (state_r)
      S_SLAVE: begin
        if (next_p_s) begin
          if (slave_ok(32'(switch_array[SLAVE_LEN-1:0]))) begin
            ld_slave_s  = 1'b1;
            err_clr_s   = 1'b1;
            state_nxt_s = S_ADDR;
          end else begin
            err_set_s   = 1'b1;
          end
        end else begin
          state_nxt_s = S_SLAVE;
        end
      end
      S_ADDR: begin
        if (back_p_s) begin
          state_nxt_s = S_SLAVE;
        end else if (next_p_s) begin
          ld_addr_s   = 1'b1;
          err_clr_s   = 1'b1;
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_ADDR;
        end
      end
      S_DATA: begin
        if (back_p_s) begin
          state_nxt_s = S_ADDR;
        end else if (next_p_s) begin
          ld_data_s   = 1'b1;
          err_clr_s   = 1'b1;
          state_nxt_s = S_BURST;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_BURST: begin
        if (back_p_s) begin
          state_nxt_s = S_DATA;
        end else if (next_p_s) begin
          if (|switch_array) begin
            ld_burst_s  = 1'b1;
            err_clr_s   = 1'b1;
            state_nxt_s = S_ARMED;
          end else begin
            err_set_s   = 1'b1;
          end
        end else begin
          state_nxt_s = S_BURST;
        end
      end
      S_ARMED: begin
        if (back_p_s) begin
          state_nxt_s = S_BURST;
        end else if (go_p_s && !master_busy) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_ARMED;
        end
      end
      S_ISSUE: begin
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (seen_busy_r && !master_busy) begin
          state_nxt_s = S_ARMED;
        end else if (!seen_busy_r && !master_busy && (wait_cnt_r == WAIT_LAST)) begin
          state_nxt_s = S_ARMED;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: begin
        state_nxt_s = S_SLAVE;
      end
    endcase
  end

  // Command field registers; rejected values are never latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slave_r   <= '0;
      address_r <= '0;
      data_r    <= '0;
      burst_r   <= '0;
    end else begin
      if (ld_slave_s) slave_r <= switch_array[SLAVE_LEN-1:0];
      else            slave_r <= slave_r;
      if (ld_addr_s)  address_r <= (ADDR_LEN+1)'(switch_array);
      else            address_r <= address_r;
      if (ld_data_s)  data_r <= switch_array[DATA_LEN-1:0];
      else            data_r <= data_r;
      if (ld_burst_s) burst_r <= (BURST_LEN+1)'(switch_array);
      else            burst_r <= burst_r;
    end
  end

  // Sticky error flag, updated only by latch attempts and timeouts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field_err_r <= 1'b0;
    end else if (err_set_s) begin
      field_err_r <= 1'b1;
    end else if (err_clr_s) begin
      field_err_r <= 1'b0;
    end else begin
      field_err_r <= field_err_r;
    end
  end

  // Busy tracking and timeout count, restarted by every strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r  <= '0;
      seen_busy_r <= 1'b0;
    end else if (state_r == S_ISSUE) begin
      wait_cnt_r  <= '0;
      seen_busy_r <= 1'b0;
    end else if (state_r == S_WAIT) begin
      seen_busy_r <= seen_busy_r | master_busy;
      if (wait_cnt_r != WAIT_LAST) wait_cnt_r <= wait_cnt_r + 4'd1;
      else                         wait_cnt_r <= wait_cnt_r;
    end else begin
      wait_cnt_r  <= wait_cnt_r;
      seen_busy_r <= seen_busy_r;
    end
  end

  // The strobe is decoded from the state register so rw_switch is taken
  // in the issue cycle itself.
  assign write        = (state_r == S_ISSUE) &  rw_switch;
  assign read         = (state_r == S_ISSUE) & ~rw_switch;
  assign slave        = slave_r;
  assign address      = address_r;
  assign data         = data_r;
  assign burst_num    = burst_r;
  assign config_state = state_r;
  assign field_err    = field_err_r;

endmodule

// File: tb/tb_master_cmd_loader.sv
// Directed bench for master_cmd_loader: table-driven field entry plus
// hand-written sequences for strobes, busy handling, glitches and reset.
module tb_master_cmd_loader;

  logic        clk;
  logic        rst;
  logic        btn_next_n;
  logic        btn_back_n;
  logic        btn_go_n;
  logic [11:0] switch_array;
  logic        rw_switch;
  logic        master_busy;
  logic        read;
  logic        write;
  logic [7:0]  data;
  logic [12:0] address;
  logic [1:0]  slave;
  logic [12:0] burst_num;
  logic [3:0]  config_state;
  logic        field_err;

  int checks;
  int failures;

  master_cmd_loader dut (
    .clk(clk), .rst(rst),
    .btn_next_n(btn_next_n), .btn_back_n(btn_back_n), .btn_go_n(btn_go_n),
    .switch_array(switch_array), .rw_switch(rw_switch), .master_busy(master_busy),
    .read(read), .write(write), .data(data), .address(address), .slave(slave),
    .burst_num(burst_num), .config_state(config_state), .field_err(field_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          act;   // 0 = next, 1 = back
    logic [11:0] sw;
    logic [3:0]  st;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  // Results of the last run_go call.
  int          n_wr, n_rd, n_both, s_tick, back_tick;
  logic [3:0]  st_before, st_at, st_after;
  logic [7:0]  d_at;
  logic [12:0] a_at, b_at;
  logic [1:0]  sl_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next_n = 1'b0;
    else if (which == 1) btn_back_n = 1'b0;
    else btn_go_n = 1'b0;
    repeat (10) tick();
    btn_next_n = 1'b1;
    btn_back_n = 1'b1;
    btn_go_n   = 1'b1;
    repeat (10) tick();
  endtask

  // Press go and watch; busy is driven 'rise' ticks after the strobe for
  // 'len' ticks (rise < 0 means busy never rises).
  task automatic run_go(input int rise, input int len);
    logic [3:0] prev;
    n_wr = 0; n_rd = 0; n_both = 0; s_tick = -1; back_tick = -1;
    st_before = 4'hF; st_at = 4'hF; st_after = 4'hF;
    d_at = '0; a_at = '0; b_at = '0; sl_at = '0;
    prev = config_state;
    btn_go_n = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (t == 10) btn_go_n = 1'b1;
      if (write) n_wr++;
      if (read) n_rd++;
      if (read && write) n_both++;
      if ((read || write) && s_tick < 0) begin
        s_tick = t; st_before = prev; st_at = config_state;
        d_at = data; a_at = address; b_at = burst_num; sl_at = slave;
      end
      if (s_tick >= 0 && t == s_tick + 1) st_after = config_state;
      if (s_tick >= 0 && t > s_tick && back_tick < 0 && config_state == 4'd4) back_tick = t;
      if (rise >= 0 && s_tick >= 0)
        master_busy = (t >= s_tick + rise) && (t < s_tick + rise + len);
      else
        master_busy = 1'b0;
      prev = config_state;
    end
    master_busy = 1'b0;
  endtask

  initial begin
    int cnt;
    checks = 0; failures = 0;
    vecs[0] = '{0, 12'h003, 4'd0, 1'b1};
    vecs[1] = '{0, 12'h001, 4'd1, 1'b0};
    vecs[2] = '{0, 12'h0A5, 4'd2, 1'b0};
    vecs[3] = '{1, 12'h000, 4'd1, 1'b0};
    vecs[4] = '{0, 12'h0A5, 4'd2, 1'b0};
    vecs[5] = '{0, 12'h03C, 4'd3, 1'b0};
    vecs[6] = '{0, 12'h000, 4'd3, 1'b1};
    vecs[7] = '{0, 12'h004, 4'd4, 1'b0};
    vecs[8] = '{1, 12'h000, 4'd3, 1'b0};
    vecs[9] = '{0, 12'h004, 4'd4, 1'b0};

    rst = 1'b0; btn_next_n = 1'b1; btn_back_n = 1'b1; btn_go_n = 1'b1;
    switch_array = '0; rw_switch = 1'b0; master_busy = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(config_state), 32'd0);
    chk("reset_outs", {read, write, field_err, slave, data}, 32'd0);
    chk("reset_addr_burst", {address, burst_num}, 32'd0);
    rst = 1'b1;
    repeat (10) tick();

    // Field entry, including rejected slave=3 and burst=0.
    for (int i = 0; i < 10; i++) begin
      switch_array = vecs[i].sw;
      press(vecs[i].act);
      chk($sformatf("vec%0d_state", i), 32'(config_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_err", i), 32'(field_err), 32'(vecs[i].err));
    end
    chk("field_slave", 32'(slave), 32'd1);
    chk("field_addr", 32'(address), 32'h0A5);
    chk("field_data", 32'(data), 32'h3C);
    chk("field_burst", 32'(burst_num), 32'd4);

    // Write with busy never rising: one strobe, 4->5->6, timeout after 8.
    rw_switch = 1'b1;
    run_go(-1, 0);
    chk("t1_writes", n_wr, 1);
    chk("t1_reads", n_rd, 0);
    chk("t1_state_before", 32'(st_before), 32'd4);
    chk("t1_state_at", 32'(st_at), 32'd5);
    chk("t1_state_after", 32'(st_after), 32'd6);
    chk("t1_fields", {sl_at, d_at, a_at}, {2'd1, 8'h3C, 13'h0A5});
    chk("t1_burst", 32'(b_at), 32'd4);
    chk("t5_timeout_ticks", back_tick - s_tick, 9);
    chk("t5_timeout_err", 32'(field_err), 32'd1);

    // Read with busy rising 2 after the strobe and falling 10 later.
    rw_switch = 1'b0;
    run_go(2, 10);
    chk("t2_reads", n_rd, 1);
    chk("t2_writes", n_wr, 0);
    chk("t2_both", n_both, 0);
    chk("t2_return_tick", back_tick - s_tick, 13);
    chk("t2_state_end", 32'(config_state), 32'd4);

    // Go while the master is busy is dropped.
    cnt = 0;
    master_busy = 1'b1;
    btn_go_n = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (read || write) cnt++;
    end
    btn_go_n = 1'b1;
    repeat (5) tick();
    master_busy = 1'b0;
    repeat (10) tick();
    if (read || write) cnt++;
    chk("t5_busy_go_strobes", cnt, 0);
    chk("t5_busy_go_state", 32'(config_state), 32'd4);

    // Back twice to S_DATA, then a short glitch and simultaneous next/back.
    press(1);
    press(1);
    chk("t4_back_to_data", 32'(config_state), 32'd2);
    btn_next_n = 1'b0;
    tick(); tick();
    btn_next_n = 1'b1;
    repeat (12) tick();
    chk("t4_glitch_state", 32'(config_state), 32'd2);
    btn_next_n = 1'b0; btn_back_n = 1'b0;
    repeat (10) tick();
    btn_next_n = 1'b1; btn_back_n = 1'b1;
    repeat (10) tick();
    chk("t4_simul_state", 32'(config_state), 32'd1);

    // Reach S_WAIT, then reset asynchronously with buttons held.
    switch_array = 12'h005;
    press(0); press(0); press(0);
    chk("t6_armed", 32'(config_state), 32'd4);
    rw_switch = 1'b1;
    btn_go_n = 1'b0;
    cnt = 0;
    while (config_state != 4'd6 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("t6_reached_wait", 32'(config_state), 32'd6);
    master_busy = 1'b1;
    btn_next_n = 1'b0;
    switch_array = 12'h001;
    #2 rst = 1'b0;
    #1;
    chk("t6_async_state", 32'(config_state), 32'd0);
    chk("t6_async_outs", {read, write, field_err, slave, data}, 32'd0);
    chk("t6_async_addr_burst", {address, burst_num}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("t6_held_no_pulse", 32'(config_state), 32'd0);
    chk("t6_held_err", 32'(field_err), 32'd0);
    btn_next_n = 1'b1; btn_go_n = 1'b1; master_busy = 1'b0;
    repeat (10) tick();
    switch_array = 12'h002;
    press(0);
    chk("t6_post_reset_next", 32'(config_state), 32'd1);
    chk("t6_post_reset_slave", 32'(slave), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
